// File: rtl/uart_pkg.sv
// Shared definitions for the UART command arbiter: FSM encoding and default widths.
package uart_pkg;

    localparam int DEF_CMD_WIDTH  = 16;
    localparam int DEF_READ_WIDTH = 8;

    // The command MSB marks a read; this is its position at the default width.
    localparam int READ_FLAG_BIT  = DEF_CMD_WIDTH - 1;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ISSUE   = 3'd1;
    localparam logic [2:0] ST_WAIT_WR = 3'd2;
    localparam logic [2:0] ST_WAIT_RD = 3'd3;
    localparam logic [2:0] ST_RESP    = 3'd4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority rotation: searches upward from ptr+1 with
// wrap-around and returns a one-hot grant plus its encoded index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/uart_cmd_arbiter.sv
// Shares one UART command engine among NUM_REQ requesters: round-robin grant,
// issue over valid/ready, wait for completion or timeout, one-cycle response.
module uart_cmd_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int CMD_WIDTH   = DEF_CMD_WIDTH,
    parameter int READ_WIDTH  = DEF_READ_WIDTH,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_vld,
    input  logic [NUM_REQ*CMD_WIDTH-1:0]   req_cmd,
    output logic [NUM_REQ-1:0]             req_rdy,
    output logic [NUM_REQ-1:0]             rsp_vld,
    output logic [READ_WIDTH-1:0]          rsp_data,
    output logic                           rsp_err,
    output logic [CMD_WIDTH-1:0]           uart_cmd,
    output logic                           uart_cmd_vld,
    input  logic                           uart_cmd_rdy,
    input  logic                           uart_read_rdy,
    input  logic [READ_WIDTH-1:0]          uart_read_data,
    output logic                           busy
);

    localparam int IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW     = $clog2(TIMEOUT_CYC + 1);
    localparam int RD_BIT = CMD_WIDTH - 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [2:0]           state_reg;
    logic [IW-1:0]        rr_ptr_reg;
    logic [IW-1:0]        owner_reg;
    logic [IW-1:0]        gnt_idx;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   owner_onehot;
    logic [TW-1:0]        tmo_cnt_reg;
    logic                 seen_low_reg;
    logic                 tmo_hit;
    logic [CMD_WIDTH-1:0] cmd_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign cmd_arr[gi]      = req_cmd[gi*CMD_WIDTH +: CMD_WIDTH];
            assign owner_onehot[gi] = (owner_reg == IW'(gi));
        end
    endgenerate

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_arb (
        .req (req_vld),
        .ptr (rr_ptr_reg),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    assign req_rdy = (state_reg == ST_IDLE) ? gnt : '0;
    assign busy    = (state_reg != ST_IDLE);
    assign tmo_hit = (tmo_cnt_reg == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            rr_ptr_reg   <= IW'(NUM_REQ - 1);
            owner_reg    <= '0;
            tmo_cnt_reg  <= '0;
            seen_low_reg <= 1'b0;
            uart_cmd     <= '0;
            uart_cmd_vld <= 1'b0;
            rsp_vld      <= '0;
            rsp_data     <= '0;
            rsp_err      <= 1'b0;
        end else begin
            // Response fields are strobes: only set on the edge entering RESP.
            rsp_vld  <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (|gnt) begin
                        uart_cmd     <= cmd_arr[gnt_idx];
                        uart_cmd_vld <= 1'b1;
                        owner_reg    <= gnt_idx;
                        rr_ptr_reg   <= gnt_idx;
                        state_reg    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (uart_cmd_rdy) begin
                        uart_cmd_vld <= 1'b0;
                        tmo_cnt_reg  <= '0;
                        seen_low_reg <= 1'b0;
                        state_reg    <= uart_cmd[RD_BIT] ? ST_WAIT_RD : ST_WAIT_WR;
                    end
                end
                ST_WAIT_WR: begin
                    tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
                    if (!uart_cmd_rdy) begin
                        seen_low_reg <= 1'b1;
                    end
                    // Ready only means "done" once it has been seen to drop.
                    if (uart_cmd_rdy && seen_low_reg) begin
                        rsp_vld   <= owner_onehot;
                        state_reg <= ST_RESP;
                    end else if (tmo_hit) begin
                        rsp_vld   <= owner_onehot;
                        rsp_err   <= 1'b1;
                        state_reg <= ST_RESP;
                    end
                end
                ST_WAIT_RD: begin
                    tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
                    if (uart_read_rdy) begin
                        rsp_vld   <= owner_onehot;
                        rsp_data  <= uart_read_data;
                        state_reg <= ST_RESP;
                    end else if (tmo_hit) begin
                        rsp_vld   <= owner_onehot;
                        rsp_err   <= 1'b1;
                        state_reg <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_arbiter.sv
// Randomized self-checking bench: transaction-level model predicts grant order,
// response latency, data and error flag from the arbitration and timeout rules.
module tb_uart_cmd_arbiter;

    localparam int NR = 4;
    localparam int CW = 16;
    localparam int RW = 8;
    localparam int T  = 100;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req_vld = '0;
    logic [NR*CW-1:0]  req_cmd = '0;
    logic [NR-1:0]     req_rdy;
    logic [NR-1:0]     rsp_vld;
    logic [RW-1:0]     rsp_data;
    logic              rsp_err;
    logic [CW-1:0]     uart_cmd;
    logic              uart_cmd_vld;
    logic              uart_cmd_rdy = 1'b1;
    logic              uart_read_rdy = 1'b0;
    logic [RW-1:0]     uart_read_data = '0;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;
    int last_gnt = NR - 1;

    uart_cmd_arbiter #(
        .NUM_REQ     (NR),
        .CMD_WIDTH   (CW),
        .READ_WIDTH  (RW),
        .TIMEOUT_CYC (T)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_vld        (req_vld),
        .req_cmd        (req_cmd),
        .req_rdy        (req_rdy),
        .rsp_vld        (rsp_vld),
        .rsp_data       (rsp_data),
        .rsp_err        (rsp_err),
        .uart_cmd       (uart_cmd),
        .uart_cmd_vld   (uart_cmd_vld),
        .uart_cmd_rdy   (uart_cmd_rdy),
        .uart_read_rdy  (uart_read_rdy),
        .uart_read_data (uart_read_data),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // First set requester after 'last', wrapping around.
    function automatic int pred_grant(input logic [NR-1:0] mask, input int last);
        for (int off = 1; off <= NR; off++) begin
            if (mask[(last + off) % NR]) return (last + off) % NR;
        end
        return 0;
    endfunction

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_cmd_vld"}, uart_cmd_vld, 0);
        check_eq({tag, "_cmd"}, uart_cmd, 0);
        check_eq({tag, "_rsp_vld"}, rsp_vld, 0);
        check_eq({tag, "_rsp_data"}, rsp_data, 0);
        check_eq({tag, "_rsp_err"}, rsp_err, 0);
        check_eq({tag, "_busy"}, busy, 0);
    endtask

    // delay: write -> cycles uart_cmd_rdy stays low after accept (0 = never drops);
    //        read  -> cycle of the read strobe after accept (0 = never).
    task automatic do_txn(input logic [NR-1:0] mask, input logic [63:0] cmds, input int delay,
                          input logic [7:0] rdata, input int hold, input bit stray, input int abort_k);
        int g;
        int exp_lat;
        int lat;
        bit is_rd;
        bit exp_err;
        logic [CW-1:0] c;
        logic [RW-1:0] exp_data;

        g = pred_grant(mask, last_gnt);
        c = cmds[g*CW +: CW];
        is_rd = c[CW-1];
        if (is_rd) exp_lat = (delay >= 1 && delay <= T) ? delay : T;
        else       exp_lat = (delay >= 1 && delay + 1 <= T) ? delay + 1 : T;
        exp_err  = is_rd ? !(delay >= 1 && delay <= T) : !(delay >= 1 && delay + 1 <= T);
        exp_data = (is_rd && !exp_err) ? rdata : '0;

        req_cmd = cmds;
        req_vld = mask;
        #1;
        check_eq("req_rdy_idle", req_rdy, 64'(1) << g);
        @(posedge clk);
        @(negedge clk);
        last_gnt = g;
        check_eq("cmd_vld_issue", uart_cmd_vld, 1);
        check_eq("uart_cmd", uart_cmd, c);
        check_eq("req_rdy_busy", req_rdy, 0);
        check_eq("busy_issue", busy, 1);

        uart_read_rdy  = stray;
        uart_read_data = 8'($urandom);
        if (hold > 0) begin
            uart_cmd_rdy = 1'b0;
            repeat (hold) begin
                @(negedge clk);
                check_eq("cmd_hold_vld", uart_cmd_vld, 1);
                check_eq("cmd_hold_val", uart_cmd, c);
            end
        end
        uart_cmd_rdy = 1'b1;
        @(negedge clk);
        uart_read_rdy = 1'b0;
        check_eq("cmd_vld_drop", uart_cmd_vld, 0);

        lat = 0;
        for (int k = 1; k <= T + 50 && lat == 0; k++) begin
            if (k == abort_k) begin
                #2;
                rst_n = 1'b0;
                #1;
                check_all_zero("rst_mid");
                req_vld = '0;
                @(negedge clk);
                rst_n = 1'b1;
                last_gnt = NR - 1;
                repeat (5) begin
                    @(negedge clk);
                    check_eq("rsp_after_rst", rsp_vld, 0);
                end
                $display("[TB] txn req=%0d cmd=%h aborted by reset", g, c);
                return;
            end
            if (is_rd) begin
                uart_read_rdy  = (k == delay);
                uart_read_data = (k == delay) ? rdata : 8'($urandom);
            end else begin
                uart_cmd_rdy = (delay > 0 && k <= delay) ? 1'b0 : 1'b1;
            end
            @(negedge clk);
            if (rsp_vld != '0) lat = k;
        end
        uart_read_rdy = 1'b0;
        uart_cmd_rdy  = 1'b1;
        req_vld       = '0;

        check_eq("latency", lat, exp_lat);
        check_eq("rsp_vld", rsp_vld, 64'(1) << g);
        check_eq("rsp_err", rsp_err, exp_err);
        check_eq("rsp_data", rsp_data, exp_data);
        $display("[TB] txn req=%0d cmd=%h %s lat=%0d err=%0b data=%h",
                 g, c, is_rd ? "RD" : "WR", lat, rsp_err, rsp_data);
        @(negedge clk);
        check_eq("rsp_one_cycle", rsp_vld, 0);
        check_eq("busy_idle", busy, 0);
    endtask

    initial begin
        int sel;
        int dly;
        logic [NR-1:0] mask;
        logic [63:0] cmds;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        check_eq("reset_req_rdy", req_rdy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset");

        // Fairness: all requesters held, writes -> grants 0,1,2,3,0.
        for (int i = 0; i < 5; i++) begin
            do_txn(4'hF, 64'h0004_0003_0002_0001, 5, 8'h00, 0, 1'b0, 0);
            check_eq("rr_order", last_gnt, i % NR);
        end

        do_txn(4'b0001, 64'h0000_0000_0000_1234, 30, 8'h00, 0, 1'b0, 0);
        do_txn(4'b0100, 64'h0000_8A00_0000_0000, 50, 8'h5C, 0, 1'b0, 0);
        do_txn(4'b0010, 64'h0000_0000_8000_0000, 0, 8'h00, 0, 1'b0, 0);
        do_txn(4'b0001, 64'h0000_0000_0000_00F1, 2, 8'h00, 1, 1'b0, 0);
        // Stray read strobes in ISSUE, real strobe on the timeout-expiry cycle.
        do_txn(4'b1000, 64'h8123_0000_0000_0000, T, 8'hA7, 2, 1'b1, 0);

        for (int i = 0; i < 40; i++) begin
            mask = 4'($urandom_range(1, 15));
            cmds = {$urandom, $urandom};
            sel  = $urandom_range(0, 9);
            case (sel)
                0:       dly = 0;
                1:       dly = T - 1;
                2:       dly = T;
                3:       dly = T + 1;
                default: dly = $urandom_range(1, 40);
            endcase
            do_txn(mask, cmds, dly, 8'($urandom), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), 0);
        end

        // Reset during WAIT_RD, then a fresh grant must go to requester 0.
        do_txn(4'b0010, 64'h0000_0000_8001_0000, 0, 8'h00, 0, 1'b0, 20);
        do_txn(4'hF, 64'h0004_0003_0002_0001, 3, 8'h00, 0, 1'b0, 0);
        check_eq("grant_after_rst", last_gnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_cmd_arbiter.md
Name: uart_cmd_arbiter

Overview:
Round-robin arbiter and transaction sequencer that shares one UART command engine among NUM_REQ requesters. It accepts one 16-bit command at a time, where the MSB set to 1 means a read. It issues the command to the UART over a valid/ready handshake and waits for completion: write-done for writes, returned read byte for reads. It then returns a one-cycle response, with data or an error flag, to the requester that owns the command. It sits between the system-side register masters and the UART block.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
CMD_WIDTH, 16, command width; bit CMD_WIDTH-1 is the read flag
READ_WIDTH, 8, width of returned read data
TIMEOUT_CYC, 200000, max cycles waited for UART completion before error

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_vld  in  NUM_REQ  per-requester command valid
req_cmd  in  NUM_REQ*CMD_WIDTH  packed commands; requester i at [i*CMD_WIDTH +: CMD_WIDTH]
req_rdy  out  NUM_REQ  per-requester accept; combinational
rsp_vld  out  NUM_REQ  one-cycle response strobe to owning requester
rsp_data  out  READ_WIDTH  read data; 0 for writes and errors
rsp_err  out  1  timeout flag, qualified by rsp_vld
uart_cmd  out  CMD_WIDTH  command to UART
uart_cmd_vld  out  1  command valid to UART
uart_cmd_rdy  in  1  UART ready; low while busy, high again when a command completes
uart_read_rdy  in  1  UART read-data strobe
uart_read_data  in  READ_WIDTH  UART read data
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, rst_n low):
  - state IDLE.
  - rr_ptr = NUM_REQ-1, so requester 0 has first priority.
  - All registered outputs are 0: uart_cmd_vld, uart_cmd, rsp_vld, rsp_data, rsp_err.
  - busy = 0.
  - Timeout counter and seen_low flag cleared.
  - Reset mid-transaction abandons the transaction; no response is issued.
- State IDLE:
  - Grant goes to the first i with req_vld[i]=1, searching from rr_ptr+1 upward with wrap-around.
  - req_rdy[grant] = 1; all other req_rdy bits are 0. req_rdy is 0 in every other state.
  - Acceptance occurs on the edge where req_vld[i] & req_rdy[i]. On that edge: latch the command and index, set rr_ptr = i, go to ISSUE.
  - A requester may drop req_vld before it is granted; there is no lock.
- State ISSUE:
  - uart_cmd_vld = 1 and uart_cmd = latched command, both registered and stable until accepted.
  - Accepted on the edge where uart_cmd_vld & uart_cmd_rdy. On that edge:
    - uart_cmd_vld goes to 0 next cycle.
    - Go to WAIT_RD if the read flag is set, otherwise WAIT_WR.
    - Clear the timeout counter and seen_low.
  - No timeout applies in ISSUE.
- State WAIT_WR:
  - Set seen_low when uart_cmd_rdy=0 is sampled.
  - Completion: uart_cmd_rdy=1 sampled while seen_low=1. Go to RESP with rsp_err=0 and rsp_data=0.
- State WAIT_RD:
  - Completion: first uart_read_rdy=1. Capture uart_read_data and go to RESP with rsp_err=0.
  - uart_read_rdy outside WAIT_RD is ignored.
- Timeout (WAIT_WR and WAIT_RD):
  - The counter increments every cycle.
  - When it reaches TIMEOUT_CYC-1 without completion: go to RESP with rsp_err=1, rsp_data=0.
  - If completion and timeout coincide on the same edge, completion wins.
  - Counter width is clog2(TIMEOUT_CYC+1).
- State RESP:
  - rsp_vld[owner] = 1 for exactly one cycle; rsp_data and rsp_err are valid in that cycle.
  - Next state is IDLE, with no extra bubble.
- Latency, UART accept edge to rsp_vld: completion edge + 1 cycle.
- Request accept edge to uart_cmd_vld high: 1 cycle.
- At most one transaction is outstanding; there is no pipelining of commands.

Decomposition:
- Shared package uart_pkg holds:
  - State encoding: IDLE=0, ISSUE=1, WAIT_WR=2, WAIT_RD=3, RESP=4, 3 bits.
  - Constant for the read-flag bit position.
  - Default CMD_WIDTH and READ_WIDTH.
- One sub-module, rr_arbiter: parameter N; inputs req[N] and ptr; output one-hot gnt[N] and encoded index. Purely combinational priority rotation.

Test Plan:
- Single write: req_vld[0]=1, cmd=0x1234, UART model drops rdy for 30 cycles -> uart_cmd=0x1234 one cycle after accept; rsp_vld[0] one cycle after rdy returns high; rsp_err=0, rsp_data=0.
- Single read: req 2, cmd=0x8A00, UART pulses read_rdy with 0x5C after 50 cycles -> rsp_vld[2] with rsp_data=0x5C, rsp_err=0.
- Round-robin fairness: all four req_vld held high, with writes -> grant order 0,1,2,3,0; no requester granted twice in a row while others wait.
- Timeout: read with TIMEOUT_CYC=100 and no read_rdy -> rsp_vld with rsp_err=1 and rsp_data=0 exactly 100 cycles after the UART accept edge; next request then accepted normally.
- Coincidence and stray strobes: read_rdy pulsed during ISSUE, then a real pulse on the timeout-expiry cycle -> early pulse ignored; response carries the data with rsp_err=0.
- Reset mid-WAIT_RD: rst_n asserted -> all outputs 0 immediately; no rsp_vld after release; next grant goes to requester 0.
